drp_adc_responder: RTL
======================

# drp_adc_responder

Synthesizable responder for the ADC dynamic-reconfiguration-port (DRP) handshake, i.e. the device side of the interface the board-level top drives into the ADC wizard. The block replaces the ADC hard macro in simulation and in the loopback build. It converts a 12-bit sample bus into periodic conversion results, pulses end-of-conversion, and serves DRP reads and writes with a fixed, parameterised latency. The existing controller (den tied to eoc, daddr, dout, drdy) connects without change.

## Interface
- CONV_CYCLES, 26: clock cycles per conversion period; legal range ≥ 2.
- DRP_LATENCY, 4: cycles from accepted den to drdy; legal range 1..15.
- CHANNEL, 7'h1E: DRP status address that holds the conversion result.
- clk  in  1  single clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- den  in  1  DRP enable; one-cycle request strobe.
- dwe  in  1  DRP write enable; qualified by den.
- daddr  in  7  DRP address; qualified by den.
- di  in  16  DRP write data; qualified by den and dwe.
- dout  out  16  DRP read data; valid while drdy is high.
- drdy  out  1  DRP done; one-cycle pulse.
- eoc  out  1  end of conversion; one-cycle pulse.
- sample  in  12  analog sample stand-in; sampled at conversion end.
- err  out  1  sticky protocol-error flag.

## Operation
- Register map. All status registers are read-only; writes to them are ignored but still complete with drdy.
  - CHANNEL: result, {sample, 4'b0}.
  - 7'h20: running maximum, same format.
  - 7'h24: running minimum, same format.
  - Other addresses in 0x00–0x3F read 16'h0000.
- Config registers 0x40–0x5F: 32 × 16-bit read/write registers. Registers 0x60–0x7F read 0 and ignore writes.
- Config 0x40 bit 0 is HOLD. When HOLD = 1:
  - the conversion timer freezes at its current count;
  - eoc is suppressed.
  - Clearing HOLD resumes counting from the frozen value.
- Conversion timer:
  - counts 0..CONV_CYCLES-1 and wraps to 0;
  - action on the terminal-count edge: load result, update max/min (unsigned 12-bit compare; ties leave them unchanged), assert eoc for exactly one cycle.
- DRP FSM has two states.
  - IDLE: den = 1 accepts the request. On acceptance, latch dwe/daddr/di and capture read data from the register state in that cycle. Then go to BUSY and load the latency counter with DRP_LATENCY-1.
  - BUSY: the counter decrements. At 0, drdy = 1 for one cycle, dout = captured data, perform the write (if dwe), and return to IDLE.
- dout holds its last read value outside drdy. Write transactions do not change dout.
- den while in BUSY, including the drdy cycle, is ignored and sets err. err clears only on rst.
- A write and a timer update in the same cycle commit independently; the two never touch the same register.

## Timing
- Reset values: dout 0, drdy 0, eoc 0, err 0, result 0, max 0, min 16'hFFF0, all config registers 0, timer 0, FSM IDLE.
- The first eoc is high in cycle CONV_CYCLES after rst deasserts; later pulses follow every CONV_CYCLES cycles.
- The result register holds the new value in the same cycle eoc is high. A den asserted during eoc therefore reads the new sample (no-skew rule for den = eoc).
- A read accepted in cycle t produces drdy in cycle t+DRP_LATENCY. Data is the register value in cycle t; a timer update in cycle t+1 or later is not reflected.
- A write accepted in cycle t is visible to a read accepted in cycle t+DRP_LATENCY+1 or later.
- DRP_LATENCY = 1: drdy is high in the cycle after den.
- The fastest back-to-back request is den in the cycle after drdy; this yields one transaction per DRP_LATENCY+1 cycles.
- rst mid-transaction cancels the pending drdy asynchronously; no write occurs.

## Test plan
- Reset check: rst pulse, then release with sample = 12'hABC. Expect eoc first high at cycle 26, and a den in that cycle to return dout = 16'hABC0 with drdy 4 cycles later.
- Loopback check: den = eoc, daddr = 7'h1E, sample ramps by +1 per period from 12'h000. Expect successive dout values 16'h0000, 16'h0010, 16'h0020, …, one per eoc, and err stays 0.
- Max/min check: samples 12'h800, 12'h100, 12'hF00, 12'h100. Expect reads of 7'h20 = 16'hF000 and 7'h24 = 16'h1000; a read before the first eoc returns 16'h0000 and 16'hFFF0.
- Config and HOLD check: write 16'h1234 to 0x45, read back 16'h1234; write 0x60, read back 0. Then write 16'h0001 to 0x40 and expect no eoc for 100 cycles. Write 0 to 0x40 and expect eoc to resume after the remaining count.
- Protocol-error check: den at t and again at t+2 with DRP_LATENCY = 4. Expect exactly one drdy (at t+4) and err = 1 until rst; the status write to 7'h1E leaves the result unchanged.
- Reset-abort check: assert rst at t+2 after a read accepted at t. Expect no drdy ever, and dout = 0.

Source files
------------

// File: rtl/drp_adc_responder_if.sv
// DRP handshake bundle between the ADC controller (master) and the
// responder standing in for the ADC hard macro (slave).
interface drp_if;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;

    modport master (
        output den,
        output dwe,
        output daddr,
        output di,
        input  dout,
        input  drdy
    );

    modport slave (
        input  den,
        input  dwe,
        input  daddr,
        input  di,
        output dout,
        output drdy
    );
endinterface

// File: rtl/drp_adc_responder.sv
// ADC DRP responder: periodic conversion of a 12-bit sample bus into a
// result register with running max/min, an end-of-conversion pulse, and a
// fixed-latency DRP slave with 32 read/write config registers.
module drp_adc_responder #(
    parameter int         CONV_CYCLES = 26,
    parameter int         DRP_LATENCY = 4,
    parameter logic [6:0] CHANNEL     = 7'h1E
) (
    input  logic        clk,
    input  logic        rst,
    drp_if.slave        drp,
    input  logic [11:0] sample,
    output logic        eoc,
    output logic        err
);
    localparam int         TW       = $clog2(CONV_CYCLES);
    localparam logic [TW-1:0] TC    = TW'(CONV_CYCLES - 1);
    localparam logic [3:0] LAT_LOAD = 4'(DRP_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     lat_reg, lat_next;
    logic           accept;
    logic           drdy_int;

    logic [TW-1:0]  timer_reg;
    logic           hold;
    logic           conv_done;

    logic [11:0]    result_reg;
    logic [11:0]    max_reg;
    logic [11:0]    min_reg;
    logic           eoc_reg;
    logic           err_reg;

    logic           wr_reg;
    logic [6:0]     addr_reg;
    logic [15:0]    wdata_reg;
    logic [15:0]    rdata_reg;
    logic [15:0]    dout_reg;
    logic [15:0]    rd_data;
    logic           cfg_we;

    logic [15:0]    cfg_reg [32];

    assign hold      = cfg_reg[0][0];
    assign conv_done = (timer_reg == TC) && !hold;

    // Conversion timer: free-running modulo counter, frozen while HOLD is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (!hold) begin
            timer_reg <= (timer_reg == TC) ? '0 : timer_reg + 1'b1;
        end
    end

    // Terminal-count actions: load result, track max/min, pulse eoc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= 12'h000;
            max_reg    <= 12'h000;
            min_reg    <= 12'hFFF;
            eoc_reg    <= 1'b0;
        end else begin
            eoc_reg <= conv_done;
            if (conv_done) begin
                result_reg <= sample;
                if (sample > max_reg) max_reg <= sample;
                if (sample < min_reg) min_reg <= sample;
            end
        end
    end

    // Read-data mux over the live register state; sampled on acceptance so
    // later timer updates never leak into an in-flight read.
    always_comb begin
        rd_data = 16'h0000;
        if (drp.daddr[6]) begin
            if (!drp.daddr[5]) rd_data = cfg_reg[drp.daddr[4:0]];
        end else if (drp.daddr == CHANNEL) begin
            rd_data = {result_reg, 4'b0000};
        end else if (drp.daddr == 7'h20) begin
            rd_data = {max_reg, 4'b0000};
        end else if (drp.daddr == 7'h24) begin
            rd_data = {min_reg, 4'b0000};
        end
    end

    // DRP FSM next-state: accept in IDLE, count down latency in BUSY.
    always_comb begin
        state_next = state_reg;
        lat_next   = lat_reg;
        accept     = 1'b0;
        drdy_int   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (drp.den) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                    lat_next   = LAT_LOAD;
                end
            end
            BUSY: begin
                if (lat_reg == 4'd0) begin
                    drdy_int   = 1'b1;
                    state_next = IDLE;
                end else begin
                    lat_next = lat_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // DRP FSM state and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            lat_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            lat_reg   <= lat_next;
        end
    end

    // Request latch, held-dout register and sticky protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_reg    <= 1'b0;
            addr_reg  <= 7'h00;
            wdata_reg <= 16'h0000;
            rdata_reg <= 16'h0000;
            dout_reg  <= 16'h0000;
            err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                wr_reg    <= drp.dwe;
                addr_reg  <= drp.daddr;
                wdata_reg <= drp.di;
                rdata_reg <= rd_data;
            end
            if (drdy_int && !wr_reg) dout_reg <= rdata_reg;
            if (drp.den && state_reg == BUSY) err_reg <= 1'b1;
        end
    end

    // Writes commit on the drdy cycle and only reach the 0x40-0x5F window.
    assign cfg_we = drdy_int && wr_reg && (addr_reg[6:5] == 2'b10);

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cfg
            // One config register per slot.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cfg_reg[gi] <= 16'h0000;
                end else if (cfg_we && addr_reg[4:0] == 5'(gi)) begin
                    cfg_reg[gi] <= wdata_reg;
                end
            end
        end
    endgenerate

    assign drp.drdy = drdy_int;
    assign drp.dout = (drdy_int && !wr_reg) ? rdata_reg : dout_reg;
    assign eoc      = eoc_reg;
    assign err      = err_reg;
endmodule
